// File: rtl/execute_stage.sv
// MIPS execute stage: ALU, HI/LO registers and a 32-step restoring divider.
// Optional macro EX_MULT_EN enables the single-cycle MULT/MULTU multiplier.
module execute_stage (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_input,
    input  logic [2:0]  alusel_input,
    input  logic [31:0] regOp1,
    input  logic [31:0] regOp2,
    input  logic [4:0]  dest_addr,
    input  logic        write_or_not,
    input  logic [31:0] ret_addr,
    input  logic        in_delayslot,
    output logic [4:0]  dest_addr_output,
    output logic        write_or_not_output,
    output logic [31:0] write_data,
    output logic        delayslot_output,
    output logic        stall_request,
    output logic [31:0] hi_output,
    output logic [31:0] lo_output
);
    localparam logic [7:0] OP_AND  = 8'h24, OP_OR   = 8'h25, OP_XOR  = 8'h26, OP_NOR  = 8'h27;
    localparam logic [7:0] OP_SLL  = 8'h7C, OP_SRL  = 8'h02, OP_SRA  = 8'h03;
    localparam logic [7:0] OP_ADD  = 8'h20, OP_ADDU = 8'h21, OP_SUB  = 8'h22, OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT  = 8'h2A, OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_MFHI = 8'h10, OP_MTHI = 8'h11, OP_MFLO = 8'h12, OP_MTLO = 8'h13;
    localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;

    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} div_state_e;

    div_state_e  state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dvsr_q, dvsr_d;
    logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [31:0] sum_s, diff_s, result_s;
    logic        add_ovf_s, sub_ovf_s, hilo_op_s, is_div_s, div_start_s;
    logic [32:0] trial_s, trial_sub_s;
    logic        we_s;

    assign sum_s       = regOp1 + regOp2;
    assign diff_s      = regOp1 - regOp2;
    assign add_ovf_s   = (regOp1[31] == regOp2[31]) && (sum_s[31] != regOp1[31]);
    assign sub_ovf_s   = (regOp1[31] != regOp2[31]) && (diff_s[31] != regOp1[31]);
    assign is_div_s    = (aluop_input == OP_DIV) || (aluop_input == OP_DIVU);
    assign div_start_s = (state_q == IDLE) && is_div_s && (regOp2 != 32'd0);
    assign hilo_op_s   = (aluop_input == OP_MTHI) || (aluop_input == OP_MTLO) ||
                         (aluop_input == OP_MULT) || (aluop_input == OP_MULTU) || is_div_s;
    assign trial_s     = {rem_q, quo_q[31]};
    assign trial_sub_s = trial_s - {1'b0, dvsr_q};

`ifdef EX_MULT_EN
    logic [63:0] mul_a_s, mul_b_s, mul_s;
    // MULT sign-extends so the low 64 bits of the product equal the signed result.
    assign mul_a_s = (aluop_input == OP_MULT) ? {{32{regOp1[31]}}, regOp1} : {32'd0, regOp1};
    assign mul_b_s = (aluop_input == OP_MULT) ? {{32{regOp2[31]}}, regOp2} : {32'd0, regOp2};
    assign mul_s   = mul_a_s * mul_b_s;
`endif

    // Result mux by class, then by opcode within the class.
    always_comb begin
        result_s = 32'd0;
        case (alusel_input)
            3'b001: case (aluop_input)
                OP_AND:  result_s = regOp1 & regOp2;
                OP_OR:   result_s = regOp1 | regOp2;
                OP_XOR:  result_s = regOp1 ^ regOp2;
                OP_NOR:  result_s = ~(regOp1 | regOp2);
                default: result_s = 32'd0;
            endcase
            3'b010: case (aluop_input)
                OP_SLL:  result_s = regOp2 << regOp1[4:0];
                OP_SRL:  result_s = regOp2 >> regOp1[4:0];
                OP_SRA:  result_s = $unsigned($signed(regOp2) >>> regOp1[4:0]);
                default: result_s = 32'd0;
            endcase
            3'b011: case (aluop_input)
                OP_ADD, OP_ADDU: result_s = sum_s;
                OP_SUB, OP_SUBU: result_s = diff_s;
                OP_SLT:  result_s = {31'd0, $signed(regOp1) < $signed(regOp2)};
                OP_SLTU: result_s = {31'd0, regOp1 < regOp2};
                default: result_s = 32'd0;
            endcase
            3'b100: case (aluop_input)
                OP_MFHI: result_s = hi_q;
                OP_MFLO: result_s = lo_q;
                default: result_s = 32'd0;
            endcase
            3'b101:  result_s = ret_addr;
            default: result_s = 32'd0;
        endcase
    end

    // Final write enable: HI/LO writers and signed overflow suppress the write.
    always_comb begin
        we_s = write_or_not;
        if (hilo_op_s) begin
            we_s = 1'b0;
        end else if ((alusel_input == 3'b011) &&
                     (((aluop_input == OP_ADD) && add_ovf_s) ||
                      ((aluop_input == OP_SUB) && sub_ovf_s))) begin
            we_s = 1'b0;
        end else begin
            we_s = write_or_not;
        end
    end

    // Divider FSM: capture magnitudes, 32 restoring steps, then sign fix-up.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        case (state_q)
            IDLE: begin
                if (div_start_s) begin
                    state_d = BUSY;
                    cnt_d   = 5'd0;
                    rem_d   = 32'd0;
                    if (aluop_input == OP_DIV) begin
                        quo_d     = regOp1[31] ? (32'd0 - regOp1) : regOp1;
                        dvsr_d    = regOp2[31] ? (32'd0 - regOp2) : regOp2;
                        neg_quo_d = regOp1[31] ^ regOp2[31];
                        neg_rem_d = regOp1[31];
                    end else begin
                        quo_d     = regOp1;
                        dvsr_d    = regOp2;
                        neg_quo_d = 1'b0;
                        neg_rem_d = 1'b0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            BUSY: begin
                // quo_q shifts the dividend out MSB-first while quotient bits shift in.
                if (trial_s >= {1'b0, dvsr_q}) begin
                    rem_d = trial_sub_s[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = trial_s[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                if (cnt_q == 5'd31) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // HI/LO next value; a finishing divide wins over any other writer.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == DONE) begin
            hi_d = neg_rem_q ? (32'd0 - rem_q) : rem_q;
            lo_d = neg_quo_q ? (32'd0 - quo_q) : quo_q;
        end else if (aluop_input == OP_MTHI) begin
            hi_d = regOp1;
        end else if (aluop_input == OP_MTLO) begin
            lo_d = regOp1;
`ifdef EX_MULT_EN
        end else if ((aluop_input == OP_MULT) || (aluop_input == OP_MULTU)) begin
            hi_d = mul_s[63:32];
            lo_d = mul_s[31:0];
`endif
        end else begin
            hi_d = hi_q;
            lo_d = lo_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 5'd0;
            rem_q     <= 32'd0;
            quo_q     <= 32'd0;
            dvsr_q    <= 32'd0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvsr_q    <= dvsr_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign dest_addr_output    = rst ? 5'd0  : dest_addr;
    assign write_or_not_output = rst ? 1'b0  : we_s;
    assign write_data          = rst ? 32'd0 : result_s;
    assign delayslot_output    = rst ? 1'b0  : in_delayslot;
    assign stall_request       = rst ? 1'b0  : (div_start_s || (state_q == BUSY));
    assign hi_output           = rst ? 32'd0 : hi_q;
    assign lo_output           = rst ? 32'd0 : lo_q;
endmodule

// File: tb/tb_execute_stage.sv
// Directed bench for execute_stage: ALU vector table plus HI/LO, divider and reset sequences.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_input;
    logic [2:0]  alusel_input;
    logic [31:0] regOp1, regOp2, ret_addr;
    logic [4:0]  dest_addr;
    logic        write_or_not, in_delayslot;
    logic [4:0]  dest_addr_output;
    logic        write_or_not_output, delayslot_output, stall_request;
    logic [31:0] write_data, hi_output, lo_output;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [2:0]  sel;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] ret;
        logic        we;
        logic [31:0] exp_data;
        logic        exp_we;
    } vec_t;
    vec_t vq[$];

    execute_stage dut (
        .clk(clk), .rst(rst), .aluop_input(aluop_input), .alusel_input(alusel_input),
        .regOp1(regOp1), .regOp2(regOp2), .dest_addr(dest_addr), .write_or_not(write_or_not),
        .ret_addr(ret_addr), .in_delayslot(in_delayslot), .dest_addr_output(dest_addr_output),
        .write_or_not_output(write_or_not_output), .write_data(write_data),
        .delayslot_output(delayslot_output), .stall_request(stall_request),
        .hi_output(hi_output), .lo_output(lo_output)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] sel, input logic [7:0] op,
                         input logic [31:0] a, input logic [31:0] b);
        alusel_input = sel;
        aluop_input  = op;
        regOp1       = a;
        regOp2       = b;
    endtask

    task automatic set_hilo(input logic [31:0] h, input logic [31:0] l);
        drive(3'b000, 8'h11, h, 32'd0);
        step();
        drive(3'b000, 8'h13, l, 32'd0);
        step();
        drive(3'b000, 8'h00, 32'd0, 32'd0);
        #1;
        chk("mthi", hi_output, h);
        chk("mtlo", lo_output, l);
    endtask

    task automatic do_div(input string name, input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp_hi,
                          input logic [31:0] exp_lo);
        logic [31:0] old_hi, old_lo;
        int cycles;
        old_hi = hi_output;
        old_lo = lo_output;
        write_or_not = 1'b1;
        drive(3'b000, op, a, b);
        #1;
        chk({name, "_we"}, {31'd0, write_or_not_output}, 32'd0);
        cycles = 0;
        while (stall_request === 1'b1 && cycles < 100) begin
            cycles++;
            step();
        end
        chk({name, "_stall_cycles"}, cycles, 32'd33);
        chk({name, "_hi_hold"}, hi_output, old_hi);
        chk({name, "_lo_hold"}, lo_output, old_lo);
        step();
        drive(3'b000, 8'h00, 32'd0, 32'd0);
        #1;
        chk({name, "_hi"}, hi_output, exp_hi);
        chk({name, "_lo"}, lo_output, exp_lo);
        chk({name, "_stall_after"}, {31'd0, stall_request}, 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        dest_addr = 5'd9;
        write_or_not = 1'b1;
        ret_addr = 32'h1234_5678;
        in_delayslot = 1'b1;
        drive(3'b001, 8'h25, 32'hF0F0_0000, 32'h0000_0F0F);
        step();
        step();
        chk("rst_data", write_data, 32'd0);
        chk("rst_we", {31'd0, write_or_not_output}, 32'd0);
        chk("rst_dest", {27'd0, dest_addr_output}, 32'd0);
        chk("rst_ds", {31'd0, delayslot_output}, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst_hi", hi_output, 32'd0);
        chk("rst_lo", lo_output, 32'd0);
        chk("rst_stall", {31'd0, stall_request}, 32'd0);

        vq.push_back(vec_t'{3'b001, 8'h25, 32'hF0F0_0000, 32'h0000_0F0F, 32'd0, 1'b1, 32'hF0F0_0F0F, 1'b1});
        vq.push_back(vec_t'{3'b001, 8'h24, 32'hFF00_FF00, 32'h0F0F_0F0F, 32'd0, 1'b1, 32'h0F00_0F00, 1'b1});
        vq.push_back(vec_t'{3'b001, 8'h26, 32'hFFFF_0000, 32'h0F0F_0F0F, 32'd0, 1'b1, 32'hF0F0_0F0F, 1'b1});
        vq.push_back(vec_t'{3'b001, 8'h27, 32'hF000_0000, 32'h0000_000F, 32'd0, 1'b1, 32'h0FFF_FFF0, 1'b1});
        vq.push_back(vec_t'{3'b001, 8'h20, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 1'b1, 32'd0, 1'b1});
        vq.push_back(vec_t'{3'b010, 8'h7C, 32'd4, 32'h0000_00F1, 32'd0, 1'b1, 32'h0000_0F10, 1'b1});
        vq.push_back(vec_t'{3'b010, 8'h02, 32'd8, 32'h8000_0000, 32'd0, 1'b1, 32'h0080_0000, 1'b1});
        vq.push_back(vec_t'{3'b010, 8'h03, 32'd4, 32'h8000_0000, 32'd0, 1'b1, 32'hF800_0000, 1'b1});
        vq.push_back(vec_t'{3'b010, 8'h03, 32'h24, 32'h8000_0000, 32'd0, 1'b1, 32'hF800_0000, 1'b1});
        vq.push_back(vec_t'{3'b011, 8'h20, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1, 32'h8000_0000, 1'b0});
        vq.push_back(vec_t'{3'b011, 8'h21, 32'h7FFF_FFFF, 32'd1, 32'd0, 1'b1, 32'h8000_0000, 1'b1});
        vq.push_back(vec_t'{3'b011, 8'h20, 32'd5, 32'hFFFF_FFFD, 32'd0, 1'b1, 32'd2, 1'b1});
        vq.push_back(vec_t'{3'b011, 8'h22, 32'h8000_0000, 32'd1, 32'd0, 1'b1, 32'h7FFF_FFFF, 1'b0});
        vq.push_back(vec_t'{3'b011, 8'h23, 32'h8000_0000, 32'd1, 32'd0, 1'b1, 32'h7FFF_FFFF, 1'b1});
        vq.push_back(vec_t'{3'b011, 8'h2A, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 32'd1, 1'b1});
        vq.push_back(vec_t'{3'b011, 8'h2B, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 32'd0, 1'b1});
        vq.push_back(vec_t'{3'b011, 8'h21, 32'd3, 32'd4, 32'd0, 1'b0, 32'd7, 1'b0});
        vq.push_back(vec_t'{3'b000, 8'h25, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b1, 32'd0, 1'b1});
        vq.push_back(vec_t'{3'b101, 8'h00, 32'd1, 32'd2, 32'hBFC0_0008, 1'b1, 32'hBFC0_0008, 1'b1});
        vq.push_back(vec_t'{3'b111, 8'h25, 32'd1, 32'd2, 32'd0, 1'b1, 32'd0, 1'b1});

        foreach (vq[i]) begin
            step();
            drive(vq[i].sel, vq[i].op, vq[i].a, vq[i].b);
            ret_addr     = vq[i].ret;
            write_or_not = vq[i].we;
            dest_addr    = i[4:0];
            in_delayslot = i[0];
            #1;
            chk($sformatf("vec%0d_data", i), write_data, vq[i].exp_data);
            chk($sformatf("vec%0d_we", i), {31'd0, write_or_not_output}, {31'd0, vq[i].exp_we});
            chk($sformatf("vec%0d_dest", i), {27'd0, dest_addr_output}, {27'd0, i[4:0]});
            chk($sformatf("vec%0d_ds", i), {31'd0, delayslot_output}, {31'd0, i[0]});
        end

        step();
        write_or_not = 1'b1;
        drive(3'b000, 8'h11, 32'h1111_1111, 32'd0);
        #1;
        chk("mthi_we", {31'd0, write_or_not_output}, 32'd0);
        set_hilo(32'h1111_1111, 32'h2222_2222);
        drive(3'b100, 8'h10, 32'd0, 32'd0);
        #1;
        chk("mfhi", write_data, 32'h1111_1111);

        step();
        do_div("div_m7_2", 8'h1A, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
        drive(3'b100, 8'h12, 32'd0, 32'd0);
        #1;
        chk("mflo_after_div", write_data, 32'hFFFF_FFFD);
        step();
        do_div("divu_100_7", 8'h1B, 32'd100, 32'd7, 32'd2, 32'd14);
        step();
        do_div("div_7_m2", 8'h1A, 32'd7, 32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFFD);

        step();
        drive(3'b000, 8'h1A, 32'd50, 32'd0);
        #1;
        chk("div0_stall", {31'd0, stall_request}, 32'd0);
        step();
        step();
        chk("div0_stall_later", {31'd0, stall_request}, 32'd0);
        chk("div0_hi", hi_output, 32'd1);
        chk("div0_lo", lo_output, 32'hFFFF_FFFD);

        drive(3'b000, 8'h1B, 32'd100, 32'd3);
        repeat (11) @(posedge clk);
        #1;
        chk("abort_busy_stall", {31'd0, stall_request}, 32'd1);
        rst = 1'b1;
        drive(3'b000, 8'h00, 32'd0, 32'd0);
        step();
        rst = 1'b0;
        #1;
        chk("abort_stall", {31'd0, stall_request}, 32'd0);
        chk("abort_hi", hi_output, 32'd0);
        chk("abort_lo", lo_output, 32'd0);
        step();
        chk("abort_stall_later", {31'd0, stall_request}, 32'd0);

        set_hilo(32'hAAAA_5555, 32'h5555_AAAA);
        write_or_not = 1'b1;
        drive(3'b000, 8'h18, 32'hFFFF_FFFE, 32'd3);
        #1;
        chk("mult_we", {31'd0, write_or_not_output}, 32'd0);
        step();
        drive(3'b000, 8'h19, 32'hFFFF_FFFF, 32'd2);
        #1;
`ifdef EX_MULT_EN
        chk("mult_hi", hi_output, 32'hFFFF_FFFF);
        chk("mult_lo", lo_output, 32'hFFFF_FFFA);
`else
        chk("mult_hi", hi_output, 32'hAAAA_5555);
        chk("mult_lo", lo_output, 32'h5555_AAAA);
`endif
        step();
        drive(3'b000, 8'h00, 32'd0, 32'd0);
        #1;
`ifdef EX_MULT_EN
        chk("multu_hi", hi_output, 32'd1);
        chk("multu_lo", lo_output, 32'hFFFF_FFFE);
`else
        chk("multu_hi", hi_output, 32'hAAAA_5555);
        chk("multu_lo", lo_output, 32'h5555_AAAA);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
